udp_rx: RTL and testbench



---
 rtl/eth_pkg.sv | 23 ++
 rtl/udp_rx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_udp_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Ethernet/IPv4/UDP constants and receive-FSM state encoding.
// Shared between the UDP receive and transmit paths.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
  localparam logic [5:0]  IP_MIN_HLEN   = 6'd20;

  typedef enum logic [7:0] {
    st_idle     = 8'b0000_0001,
    st_preamble = 8'b0000_0010,
    st_eth_head = 8'b0000_0100,
    st_ip_head  = 8'b0000_1000,
    st_udp_head = 8'b0001_0000,
    st_rx_data  = 8'b0010_0000,
    st_rx_end   = 8'b0100_0000,
    st_err      = 8'b1000_0000
  } rx_state_t;

endpackage

// File: rtl/udp_rx.sv
// GMII UDP/IPv4 receiver: strips preamble and headers, filters on MAC/type/proto/IP,
// and streams the UDP payload with a completion pulse carrying the byte count.
module udp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [7:0]  rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num,
  output logic        rec_err,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  rx_state_t   r_state;
  rx_state_t   w_next;

  logic        r_dv_p0;
  logic [7:0]  r_rxd_p0;
  logic [5:0]  r_cnt;
  logic [5:0]  r_ip_hlen;
  logic        r_uni_miss;
  logic        r_bc_miss;
  logic        r_type_miss;
  logic        r_ip_bad;
  logic [47:0] r_mac_sh;
  logic [31:0] r_ip_sh;
  logic [15:0] r_udp_len;
  logic [15:0] r_data_num;
  logic [15:0] r_data_cnt;

  logic        w_uni_miss;
  logic        w_bc_miss;
  logic        w_type_miss;
  logic        w_eth_ok;
  logic        w_ihl_bad;
  logic        w_ip_bad;
  logic        w_ip_end;
  logic        w_last;
  logic        w_en;
  logic        w_done;
  logic        w_err;

  function automatic logic [7:0] mac_byte(input logic [5:0] idx);
    logic [7:0] b;
    case (idx)
      6'd0:    b = BOARD_MAC[47:40];
      6'd1:    b = BOARD_MAC[39:32];
      6'd2:    b = BOARD_MAC[31:24];
      6'd3:    b = BOARD_MAC[23:16];
      6'd4:    b = BOARD_MAC[15:8];
      6'd5:    b = BOARD_MAC[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ip_byte(input logic [5:0] idx);
    logic [7:0] b;
    case (idx)
      6'd16:   b = BOARD_IP[31:24];
      6'd17:   b = BOARD_IP[23:16];
      6'd18:   b = BOARD_IP[15:8];
      6'd19:   b = BOARD_IP[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Stage p0: GMII input register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv_p0  <= 1'b0;
      r_rxd_p0 <= 8'h00;
    end else begin
      r_dv_p0  <= gmii_rx_dv;
      r_rxd_p0 <= gmii_rxd;
    end
  end

  // Header checks fold the current byte into the sticky miss flags so the
  // decision on the last header byte needs no extra cycle.
  always_comb begin
    w_uni_miss  = r_uni_miss | ((r_cnt < 6'd6) && (r_rxd_p0 != mac_byte(r_cnt)));
    w_bc_miss   = r_bc_miss  | ((r_cnt < 6'd6) && (r_rxd_p0 != 8'hFF));
    w_type_miss = r_type_miss
                | ((r_cnt == 6'd12) && (r_rxd_p0 != ETH_TYPE_IPV4[15:8]))
                | ((r_cnt == 6'd13) && (r_rxd_p0 != ETH_TYPE_IPV4[7:0]));
    w_eth_ok    = !(w_uni_miss && w_bc_miss) && !w_type_miss;
    w_ihl_bad   = (r_cnt == 6'd0) &&
                  ((r_rxd_p0[7:4] != 4'd4) || ({r_rxd_p0[3:0], 2'b00} < IP_MIN_HLEN));
    w_ip_bad    = r_ip_bad
                | ((r_cnt == 6'd9) && (r_rxd_p0 != IP_PROTO_UDP))
                | ((r_cnt >= 6'd16) && (r_cnt <= 6'd19) && (r_rxd_p0 != ip_byte(r_cnt)));
    w_ip_end    = (r_cnt != 6'd0) && (r_cnt == r_ip_hlen - 6'd1);
    w_last      = (r_data_cnt == r_data_num - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= st_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      st_idle: begin
        if (r_dv_p0) w_next = (r_rxd_p0 == PREAMBLE_BYTE) ? st_preamble : st_err;
      end
      st_preamble: begin
        if (!r_dv_p0) begin
          w_next = st_idle;
          w_err  = 1'b1;
        end else if ((r_rxd_p0 == PREAMBLE_BYTE) && (r_cnt < 6'd7)) begin
          w_next = st_preamble;
        end else if ((r_rxd_p0 == SFD_BYTE) && (r_cnt >= 6'd1)) begin
          w_next = st_eth_head;
        end else begin
          w_next = st_err;
        end
      end
      st_eth_head: begin
        if (!r_dv_p0) begin
          w_next = st_idle;
          w_err  = 1'b1;
        end else if (r_cnt == 6'd13) begin
          w_next = w_eth_ok ? st_ip_head : st_err;
        end
      end
      st_ip_head: begin
        if (!r_dv_p0) begin
          w_next = st_idle;
          w_err  = 1'b1;
        end else if (w_ihl_bad) begin
          w_next = st_err;
        end else if (w_ip_end) begin
          w_next = w_ip_bad ? st_err : st_udp_head;
        end
      end
      st_udp_head: begin
        if (!r_dv_p0) begin
          w_next = st_idle;
          w_err  = 1'b1;
        end else if (r_cnt == 6'd7) begin
          if (r_udp_len < UDP_HDR_LEN) begin
            w_next = st_err;
          end else if (r_udp_len == UDP_HDR_LEN) begin
            w_done = 1'b1;
            w_next = st_rx_end;
          end else begin
            w_next = st_rx_data;
          end
        end
      end
      st_rx_data: begin
        if (!r_dv_p0) begin
          w_next = st_idle;
          w_err  = 1'b1;
        end else begin
          w_en = 1'b1;
          if (w_last) begin
            w_done = 1'b1;
            w_next = st_rx_end;
          end
        end
      end
      st_rx_end: begin
        if (!r_dv_p0) w_next = st_idle;
      end
      st_err: begin
        if (!r_dv_p0) w_next = st_idle;
      end
      default: w_next = st_idle;
    endcase
    if ((w_next == st_err) && (r_state != st_err)) w_err = 1'b1;
  end

  // Stage p1: header field capture and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 6'd0;
      r_ip_hlen   <= 6'd0;
      r_uni_miss  <= 1'b0;
      r_bc_miss   <= 1'b0;
      r_type_miss <= 1'b0;
      r_ip_bad    <= 1'b0;
      r_mac_sh    <= 48'h0;
      r_ip_sh     <= 32'h0;
      r_udp_len   <= 16'h0;
      r_data_num  <= 16'h0;
      r_data_cnt  <= 16'h0;
    end else begin
      unique case (r_state)
        st_idle: begin
          r_cnt       <= 6'd1;
          r_uni_miss  <= 1'b0;
          r_bc_miss   <= 1'b0;
          r_type_miss <= 1'b0;
          r_ip_bad    <= 1'b0;
          r_data_cnt  <= 16'h0;
        end
        st_preamble: begin
          r_cnt <= (w_next == st_eth_head) ? 6'd0 : r_cnt + 6'd1;
        end
        st_eth_head: begin
          r_uni_miss  <= w_uni_miss;
          r_bc_miss   <= w_bc_miss;
          r_type_miss <= w_type_miss;
          if ((r_cnt >= 6'd6) && (r_cnt < 6'd12)) r_mac_sh <= {r_mac_sh[39:0], r_rxd_p0};
          r_cnt <= (r_cnt == 6'd13) ? 6'd0 : r_cnt + 6'd1;
        end
        st_ip_head: begin
          if (r_cnt == 6'd0) r_ip_hlen <= {r_rxd_p0[3:0], 2'b00};
          r_ip_bad <= w_ip_bad;
          if ((r_cnt >= 6'd12) && (r_cnt < 6'd16)) r_ip_sh <= {r_ip_sh[23:0], r_rxd_p0};
          r_cnt <= (w_next == st_udp_head) ? 6'd0 : r_cnt + 6'd1;
        end
        st_udp_head: begin
          if (r_cnt == 6'd4) r_udp_len[15:8] <= r_rxd_p0;
          if (r_cnt == 6'd5) r_udp_len[7:0]  <= r_rxd_p0;
          if (r_cnt == 6'd7) r_data_num      <= r_udp_len - UDP_HDR_LEN;
          r_data_cnt <= 16'h0;
          r_cnt      <= r_cnt + 6'd1;
        end
        st_rx_data: begin
          if (r_dv_p0) r_data_cnt <= r_data_cnt + 16'd1;
        end
        default: begin
          r_cnt <= 6'd0;
        end
      endcase
    end
  end

  // Stage p2: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_en       <= 1'b0;
      rec_data     <= 8'h00;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= 16'h0;
      rec_err      <= 1'b0;
      src_mac      <= 48'h0;
      src_ip       <= 32'h0;
    end else begin
      rec_en       <= w_en;
      rec_pkt_done <= w_done;
      rec_err      <= w_err;
      if (w_en) rec_data <= r_rxd_p0;
      if (w_done) begin
        rec_byte_num <= (r_state == st_rx_data) ? r_data_num : 16'h0;
        src_mac      <= r_mac_sh;
        src_ip       <= r_ip_sh;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
// Scoreboard bench for udp_rx: builds GMII frames, queues expected payload/done/err
// events as frames are driven, and checks them as the receiver emits them.
module tb_udp_rx;

  localparam logic [47:0] MY_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] MY_IP  = {8'd192, 8'd168, 8'd1, 8'd10};

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        rec_err;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  udp_rx #(.BOARD_MAC(MY_MAC), .BOARD_IP(MY_IP)) dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .rec_err      (rec_err),
    .src_mac      (src_mac),
    .src_ip       (src_ip)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic [31:0] ip;
    logic [47:0] mac;
  } done_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          err_seen = 0;
  int          err_pushed = 0;
  logic [7:0]  exp_q[$];
  done_t       done_q[$];
  logic [7:0]  fr[$];
  logic [7:0]  pl[$];
  logic [47:0] cur_smac;
  logic [31:0] cur_sip;
  logic [47:0] last_mac = 48'h0;
  logic [31:0] last_ip  = 32'h0;
  logic [15:0] last_num = 16'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rec_en) begin
      if (exp_q.size() == 0) check("en_unexp", 64'(rec_en), 64'd0);
      else                   check("data", 64'(rec_data), 64'(exp_q.pop_front()));
    end
    if (rec_pkt_done) begin
      if (done_q.size() == 0) begin
        check("done_unexp", 64'(rec_pkt_done), 64'd0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        check("byte_num", 64'(rec_byte_num), 64'(d.num));
        check("src_ip", 64'(src_ip), 64'(d.ip));
        check("src_mac", 64'(src_mac), 64'(d.mac));
        check("en_with_done", 64'(rec_en), 64'(d.num != 16'd0));
      end
    end
    if (rec_err) err_seen++;
  end

  task automatic push16(input logic [15:0] v);
    fr.push_back(v[15:8]);
    fr.push_back(v[7:0]);
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [7:0] proto, input logic [31:0] dip, input logic [3:0] ihl);
    int start;
    int hl;
    logic [15:0] ulen;
    fr.delete();
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    start = fr.size();
    for (int i = 5; i >= 0; i--) fr.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(cur_smac[i*8 +: 8]);
    push16(etype);
    hl   = int'(ihl) * 4;
    ulen = 16'(pl.size() + 8);
    fr.push_back({4'h4, ihl});
    fr.push_back(8'h00);
    push16(16'(hl) + ulen);
    push16(16'h0000);
    push16(16'h4000);
    fr.push_back(8'h40);
    fr.push_back(proto);
    push16(16'h0000);
    for (int i = 3; i >= 0; i--) fr.push_back(cur_sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(dip[i*8 +: 8]);
    for (int i = 20; i < hl; i++) fr.push_back(8'h01);
    push16(16'h1234);
    push16(16'h5678);
    push16(ulen);
    push16(16'h0000);
    foreach (pl[i]) fr.push_back(pl[i]);
    while (fr.size() - start < 60) fr.push_back(8'h00);
    fr.push_back(8'hC3);
    fr.push_back(8'h5A);
    fr.push_back(8'h99);
    fr.push_back(8'h17);
  endtask

  task automatic expect_ok();
    done_t d;
    foreach (pl[i]) exp_q.push_back(pl[i]);
    d.num = 16'(pl.size());
    d.ip  = cur_sip;
    d.mac = cur_smac;
    done_q.push_back(d);
    last_ip  = cur_sip;
    last_mac = cur_smac;
    last_num = d.num;
  endtask

  task automatic drive(input int cut, input int rst_at);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == cut) break;
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fr[i];
      rst        = (i == rst_at);
    end
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    rst        = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic frame_end(input string tag);
    check({tag, "_data_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_left"}, 64'(done_q.size()), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_seen), 64'(err_pushed));
  endtask

  task automatic check_held(input string tag);
    check({tag, "_held_ip"}, 64'(src_ip), 64'(last_ip));
    check({tag, "_held_mac"}, 64'(src_mac), 64'(last_mac));
    check({tag, "_held_num"}, 64'(rec_byte_num), 64'(last_num));
  endtask

  initial begin
    rst        = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    cur_smac   = 48'hA0_B1_C2_D3_E4_F5;
    cur_sip    = {8'd192, 8'd168, 8'd1, 8'd102};
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 64'(rec_en), 64'd0);
    check("rst_data", 64'(rec_data), 64'd0);
    check("rst_done", 64'(rec_pkt_done), 64'd0);
    check("rst_num", 64'(rec_byte_num), 64'd0);
    check("rst_err", 64'(rec_err), 64'd0);
    check("rst_mac", 64'(src_mac), 64'd0);
    check("rst_ip", 64'(src_ip), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd5);
    expect_ok();
    drive(-1, -1);
    frame_end("t1");

    pl.delete();
    for (int i = 0; i < 30; i++) pl.push_back(8'(i));
    cur_smac = 48'h02_00_00_00_00_07;
    build(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 8'd17, MY_IP, 4'd5);
    expect_ok();
    drive(-1, -1);
    frame_end("t2");

    pl = '{8'h11, 8'h22, 8'h33};
    cur_sip = {8'd192, 8'd168, 8'd1, 8'd103};
    build(MY_MAC, 16'h0800, 8'd17, {8'd192, 8'd168, 8'd1, 8'd11}, 4'd5);
    err_pushed++;
    drive(-1, -1);
    frame_end("t3_badip");
    check_held("t3");
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd5);
    expect_ok();
    drive(-1, -1);
    frame_end("t3_next");

    cur_sip = {8'd10, 8'd0, 8'd0, 8'd1};
    cur_smac = 48'h02_AA_BB_CC_DD_EE;
    build(MY_MAC, 16'h0806, 8'd17, MY_IP, 4'd5);
    err_pushed++;
    drive(-1, -1);
    frame_end("t4_arp");
    build(MY_MAC, 16'h0800, 8'd6, MY_IP, 4'd5);
    err_pushed++;
    drive(-1, -1);
    frame_end("t4_tcp");
    check_held("t4");

    pl = '{8'h5A};
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd6);
    expect_ok();
    drive(-1, -1);
    frame_end("t5");

    pl.delete();
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd5);
    expect_ok();
    drive(-1, -1);
    frame_end("t_zero");

    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'hA0 + i));
    cur_sip = {8'd192, 8'd168, 8'd1, 8'd200};
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd5);
    for (int i = 0; i < 3; i++) exp_q.push_back(pl[i]);
    err_pushed++;
    drive(53, -1);
    frame_end("t6_cut");
    check_held("t6_cut");

    pl = '{8'h77, 8'h88, 8'h99, 8'hAA};
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd5);
    err_pushed++;
    drive(-1, 24);
    frame_end("t6_rst");

    cur_sip = {8'd192, 8'd168, 8'd1, 8'd50};
    pl = '{8'hC0, 8'hFF, 8'hEE};
    build(MY_MAC, 16'h0800, 8'd17, MY_IP, 4'd5);
    expect_ok();
    drive(-1, -1);
    frame_end("t6_next");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
